// File: rtl/multdiv_seq_if.sv
// rtl/multdiv_seq_if.sv - operand/control/result bundle for the iterative multiply/divide unit
interface multdiv_seq_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output data_operandA,
        output data_operandB,
        output ctrl_MULT,
        output ctrl_DIV,
        input  data_result,
        input  data_exception,
        input  data_resultRDY
    );

    modport slave (
        input  data_operandA,
        input  data_operandB,
        input  ctrl_MULT,
        input  ctrl_DIV,
        output data_result,
        output data_exception,
        output data_resultRDY
    );
endinterface

// File: rtl/multdiv_seq.sv
// rtl/multdiv_seq.sv - iterative signed radix-2 multiply / restoring divide, one step per clock
// Optional feature macro: MULTDIV_EARLY_DIV0_EN (divide by zero completes right after the start cycle)
module multdiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clock,
    input  logic          resetn,
    multdiv_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             neg_q, neg_d;
    logic             bzero_q, bzero_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    logic             start;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_step;

    assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
    assign abs_a     = magnitude(bus.data_operandA);
    assign abs_b     = magnitude(bus.data_operandB);
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign last_step = (cnt_inc == CNT_W'(WIDTH));

    // Multiply step: hi accumulates the multiplicand, {carry,hi,lo} shifts right one place.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi, mul_lo, mul_res;
    logic [2*WIDTH-1:0] mul_prod, mul_signed;
    logic [WIDTH:0]     mul_top;
    logic               mul_exc;

    assign mul_sum    = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opnd_q}) : {1'b0, hi_q};
    assign mul_hi     = mul_sum[WIDTH:1];
    assign mul_lo     = {mul_sum[0], lo_q[WIDTH-1:1]};
    assign mul_prod   = {mul_hi, mul_lo};
    assign mul_signed = neg_q ? (~mul_prod + (2*WIDTH)'(1)) : mul_prod;
    assign mul_res    = mul_signed[WIDTH-1:0];
    assign mul_top    = mul_signed[2*WIDTH-1:WIDTH-1];
    assign mul_exc    = ~((&mul_top) | (~|mul_top));

    // Divide step: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi, div_lo, div_q_signed, div_res;
    logic             div_exc;

    assign div_shift    = {hi_q, lo_q[WIDTH-1]};
    assign div_diff     = div_shift - {1'b0, opnd_q};
    assign div_ge       = ~div_diff[WIDTH];
    assign div_hi       = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_lo       = {lo_q[WIDTH-2:0], div_ge};
    assign div_q_signed = neg_q ? (~div_lo + WIDTH'(1)) : div_lo;
    assign div_res      = bzero_q ? '0 : div_q_signed;
    assign div_exc      = bzero_q | ovf_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            bzero_q  <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            bzero_q  <= bzero_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        bzero_d  = bzero_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;

        case (state_q)
            ST_MUL: begin
                hi_d  = mul_hi;
                lo_d  = mul_lo;
                cnt_d = cnt_inc;
                if (last_step) begin
                    state_d  = ST_DONE;
                    result_d = mul_res;
                    exc_d    = mul_exc;
                end
            end
            ST_DIV: begin
                hi_d  = div_hi;
                lo_d  = div_lo;
                cnt_d = cnt_inc;
`ifdef MULTDIV_EARLY_DIV0_EN
                if (bzero_q) begin
                    state_d  = ST_DONE;
                    result_d = '0;
                    exc_d    = 1'b1;
                end else
`endif
                if (last_step) begin
                    state_d  = ST_DONE;
                    result_d = div_res;
                    exc_d    = div_exc;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A start in any state wins and silently drops whatever was in flight.
        if (start) begin
            state_d = bus.ctrl_MULT ? ST_MUL : ST_DIV;
            cnt_d   = '0;
            hi_d    = '0;
            lo_d    = bus.ctrl_MULT ? abs_b : abs_a;
            opnd_d  = bus.ctrl_MULT ? abs_a : abs_b;
            neg_d   = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            bzero_d = (bus.data_operandB == '0);
            ovf_d   = (bus.data_operandA == INT_MIN) && (bus.data_operandB == '1);
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = (state_q == ST_DONE);
endmodule
